// File: rtl/encoder_16_to_4_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot request mask and emits the
// index of every set bit, lowest first, one per valid/ready handshake.
//
// Handshake: code/last are meaningful while valid=1; a transfer completes on a
// rising edge where valid=1 and ready=1. With ready=0, code, last and the
// pending mask hold unchanged indefinitely.
module encoder_16_to_4_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] req,
  input  logic        start,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic        last,
  output logic        busy,
  output logic [4:0]  total,
  output logic        none
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pending;
  logic [15:0] pending_next;

  function automatic logic [3:0] lsb_index(input logic [15:0] v);
    lsb_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lsb_index = 4'(i);
    end
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    popcount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popcount = popcount + 5'(v[i]);
    end
  endfunction

  function automatic logic single_bit(input logic [15:0] v);
    single_bit = (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // Clearing the lowest set bit is the same as clearing the bit at code.
  assign pending_next = pending & (pending - 16'd1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      pending <= 16'd0;
      code    <= 4'd0;
      valid   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      total   <= 5'd0;
      none    <= 1'b0;
    end else begin
      none <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pending <= req;
            total   <= popcount(req);
            if (req != 16'd0) begin
              state <= SCAN;
              valid <= 1'b1;
              busy  <= 1'b1;
              code  <= lsb_index(req);
              last  <= single_bit(req);
            end else begin
              none <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (ready) begin
            if (last) begin
              state   <= IDLE;
              pending <= 16'd0;
              valid   <= 1'b0;
              busy    <= 1'b0;
              last    <= 1'b0;
              code    <= 4'd0;
            end else begin
              pending <= pending_next;
              code    <= lsb_index(pending_next);
              last    <= single_bit(pending_next);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/encoder_16_to_4_seq.md
# encoder_16_to_4_seq

Sequential 16-to-4 encoder: the inverse of the datapath's 4-to-16 register-select decoder. It captures a 16-bit multi-hot request mask on `start`. It then emits the 4-bit index of every set bit, lowest index first, one per valid/ready handshake. It sits between control logic that raises several register-select lines at once (multi-register transfers, for example) and the 4-bit register-address inputs that drive the decoder.

## Interface
- No parameters; widths fixed at 16 request lines / 4-bit code.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous active-low reset.
- `req`  in  16  request mask, sampled only on an accepted `start`.
- `start`  in  1  capture request; accepted only when `busy`=0.
- `ready`  in  1  consumer accepts the current `code` this cycle.
- `code`  out  4  index of the lowest pending set bit.
- `valid`  out  1  `code` is meaningful.
- `last`  out  1  the current `code` is the final pending bit.
- `busy`  out  1  scan in progress; `start` is ignored.
- `total`  out  5  population count of the captured mask, 0..16; held until the next accepted `start`.
- `none`  out  1  one-cycle pulse: the captured mask was zero.

## Operation
- State machine states: IDLE and SCAN.
- Internal 16-bit `pending` register.
- Reset (`clr`=0, asynchronous): state=IDLE, `pending`=0. All outputs read 0: `code`, `valid`, `last`, `busy`, `total`, `none`.
- IDLE, `start`=1:
  - `pending`<=`req` and `total`<=popcount(`req`).
  - If `req`≠0: go to SCAN.
  - If `req`=0: stay in IDLE and assert `none` for exactly the next cycle.
- IDLE, `start`=0: hold. `none` returns to 0.
- SCAN:
  - `valid`=1 and `busy`=1.
  - `code` = index of the least-significant set bit of `pending`.
  - `last`=1 exactly when `pending` has a single set bit.
- Handshake completes when `valid`=1 and `ready`=1 on a rising edge:
  - The bit at `code` is cleared in `pending`.
  - If `last` was 1, go to IDLE. `valid`, `busy` and `last` drop to 0, and `pending`=0.
- `valid`=1 with `ready`=0: `code`, `last` and `pending` hold unchanged. There is no timeout.
- `start` is ignored in SCAN and does not disturb `pending` or `total`.
- `req` is ignored except on the accepted `start` edge.
- `code` is registered (driven from `pending`). It reads 0 whenever `valid`=0.
- Bit 15 set alone encodes to 4'hF. The all-ones mask produces 16 codes, 0..15, with `total`=5'd16.

## Timing
- Latency: an accepted `start` at edge N gives `valid`=1 with the first `code` after edge N, i.e. during cycle N+1.
- Throughput: with `ready` held high, one code per cycle. A mask with k set bits occupies SCAN for exactly k cycles.
- Back-to-back operation: after the edge that accepts the last code, the block is in IDLE. A new `start` may be accepted on the following edge, giving one idle cycle between scans.
- `none`: high only during the single cycle following the accepting edge. `busy` never asserts for a zero mask.
- Reset mid-scan: outputs clear immediately and asynchronously. Release of `clr` leaves the block in IDLE; the interrupted scan does not resume.
- All outputs change only on the rising edge of `clk` or on assertion of `clr`.

## Test plan
- Reset: `clr`=0 mid-scan with mask 16'h00F0 -> all outputs 0 at once; after release `busy`=0 and no `valid` appears without a new `start`.
- Single bit: `req`=16'h8000, `start` pulse, `ready`=1 -> one cycle of `valid`=1, `code`=4'hF, `last`=1, `total`=5'd1; then IDLE.
- Multi-hot streaming: `req`=16'h0A05, `ready`=1 -> consecutive codes 0, 2, 9, 11; `last` high only with 11; `total`=5'd4.
- Backpressure: `req`=16'h0006, `ready`=0 for 3 cycles then 1 -> `code`=1 held for 4 cycles, then `code`=2 with `last`=1.
- Zero mask and ignored start: `req`=0 with `start` -> `none` pulses one cycle, `total`=0, `valid` never rises. Then `req`=16'h0003 with `start`, and `start` pulsed again with `req`=16'hFFFF during SCAN -> only codes 0 and 1 are emitted.
- Full mask: `req`=16'hFFFF, `ready`=1 -> 16 consecutive codes 0..15, `total`=5'd16, `last` only on 15, `busy` high for exactly 16 cycles.
